// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle mult/multu/div/divu with a fixed busy window,
// plus single-cycle mthi/mtlo writes to the architectural HI/LO registers.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic { IDLE, RUN } state_t;
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d, op_in;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  // Datapath works on the latched operands only.
  logic [63:0] a_ext, b_ext, prod;
  logic        is_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvsr, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    a_ext     = {(is_signed && a_q[31]) ? 32'hFFFF_FFFF : 32'h0, a_q};
    b_ext     = {(is_signed && b_q[31]) ? 32'hFFFF_FFFF : 32'h0, b_q};
    prod      = a_ext * b_ext;

    // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    neg_a = is_signed && a_q[31];
    neg_b = is_signed && b_q[31];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    dvsr  = (mag_b == '0) ? 32'd1 : mag_b;
    q_mag = mag_a / dvsr;
    r_mag = mag_a % dvsr;
    quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_in   = op_t'(MDU_op);

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = 4'(MULT_CYCLES);
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = 4'(DIV_CYCLES);
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy window lengths,
// request gating while busy, divide-by-zero hold and mid-operation reset.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDU_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDU_op(MDU_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle, then scrambles A/B to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDU_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDU_op = 3'd0; A = $urandom; B = $urandom;
  endtask

  // Counts negedge samples with busy high (bounded), starting at first busy sample.
  task automatic wait_busy(input string tag, input int unsigned already, input int unsigned exp_n);
    int unsigned n = already;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; MDU_op = 3'd0; A = '0; B = '0;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // mult -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_rise", {31'b0, busy}, 32'd1);
    chk("mult_hold_lo", LO, 32'h0);
    wait_busy("mult_busy_len", 0, 5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3
    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_busy("multu_busy_len", 0, 5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_hold_hi", HI, 32'h0000_0002);
    wait_busy("div_busy_len", 0, 10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // divu 7 / 2
    issue(3'd4, 32'd7, 32'd2);
    wait_busy("divu_busy_len", 0, 10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // div 7 / -2
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_busy("div_negb_len", 0, 10);
    chk("div_negb_lo", LO, 32'hFFFF_FFFD);
    chk("div_negb_hi", HI, 32'd1);

    // div overflow case
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("div_ovf_len", 0, 10);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'h0);

    // back-to-back mthi/mtlo, busy never asserted
    @(negedge clk);
    start = 1'b1; MDU_op = 3'd5; A = 32'd1;
    @(negedge clk);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'd1);
    MDU_op = 3'd6; A = 32'd2;
    @(negedge clk);
    start = 1'b0; MDU_op = 3'd0;
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_lo", LO, 32'd2);
    chk("mtlo_hi_kept", HI, 32'd1);

    // preload 0x11/0x22 then divide by zero
    issue(3'd5, 32'h11, 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    issue(3'd3, 32'd5, 32'd0);
    wait_busy("div0_busy_len", 0, 10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    // reserved/none ops are no-ops
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("op7_busy", {31'b0, busy}, 32'd0);
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    chk("op0_busy", {31'b0, busy}, 32'd0);
    chk("noop_hi", HI, 32'h11);
    chk("noop_lo", LO, 32'h22);

    // mtlo during busy is ignored; 0x10000*0x10000 = 1_00000000
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    start = 1'b1; MDU_op = 3'd6; A = 32'hABCD;
    @(negedge clk);
    start = 1'b0; MDU_op = 3'd0;
    wait_busy("mult_ign_len", 2, 5);
    chk("mult_ign_lo", LO, 32'h0);
    chk("mult_ign_hi", HI, 32'h1);

    // reset during div: abandoned, then a fresh mult on the first edge after release
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; MDU_op = 3'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; MDU_op = 3'd0;
    chk("post_rst_busy", {31'b0, busy}, 32'd1);
    chk("post_rst_hold", LO, 32'h0);
    wait_busy("post_rst_len", 0, 5);
    chk("post_rst_lo", LO, 32'd12);
    chk("post_rst_hi", HI, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
